// File: rtl/mem_array_pkg.sv
// Shared types and constants for the memory array arbiter.
package mem_array_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_READ,
        ST_SLEEP,
        ST_WAKE
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/mem_idle_timer.sv
// Saturating idle-cycle counter; expired once LIMIT consecutive enabled
// cycles have been seen since the last clear.
module mem_idle_timer #(
    parameter int LIMIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over count; hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q >= CNT_W'(LIMIT));

endmodule

// File: rtl/mem_array_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 8x8 memory array.
// Optional idle sleep is compiled in with MEM_ARRAY_ARBITER_SLEEP_EN.
module mem_array_arbiter
    import mem_array_pkg::*;
#(
    parameter int DATA_W            = MEM_DATA_W,
    parameter int ADDR_W            = MEM_ADDR_W,
    parameter int IDLE_SLEEP_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_out,
    output logic              sleep
);

    if (IDLE_SLEEP_CYCLES < 1 || IDLE_SLEEP_CYCLES > 255) begin : g_bad_idle
        $error("IDLE_SLEEP_CYCLES must be in 1..255");
    end

    arb_state_t        state_q, state_d;
    port_id_t          ptr_q, ptr_d;
    port_id_t          grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic              mem_rw_q, mem_rw_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              any_req;
    port_id_t          sel;

    assign any_req = a_req | b_req;
    assign sel     = (a_req && b_req) ? ptr_q : (b_req ? PORT_B : PORT_A);

`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
    logic idle_expired;
    logic sleep_q, sleep_d;

    mem_idle_timer #(
        .LIMIT (IDLE_SLEEP_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_q != ST_IDLE) || any_req),
        .en      (state_q == ST_IDLE),
        .expired (idle_expired)
    );

    assign sleep = sleep_q;
`else
    assign sleep = 1'b0;
`endif

    // Next-state, arbitration and datapath capture; strobes/acks are
    // registered from the next state so they line up with that state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        we_d       = we_q;
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    // Address/data are loaded on entry so they are already
                    // on the array during SETUP, one cycle ahead of mem_rw.
                    grant_d    = sel;
                    we_d       = (sel == PORT_B) ? b_we    : a_we;
                    mem_addr_d = (sel == PORT_B) ? b_addr  : a_addr;
                    mem_in_d   = (sel == PORT_B) ? b_wdata : a_wdata;
                    state_d    = ST_SETUP;
                end
`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
                else if (idle_expired) begin
                    state_d = ST_SLEEP;
                end
`endif
            end
            ST_SETUP: begin
                state_d = we_q ? ST_WRITE : ST_READ;
                // Array output is valid in SETUP; capture so rdata is
                // presented together with the ack in READ.
                if (!we_q) begin
                    if (grant_q == PORT_B) b_rdata_d = mem_out;
                    else                   a_rdata_d = mem_out;
                end
            end
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD, ST_READ: begin
                state_d = ST_IDLE;
                ptr_d   = other_port(grant_q);
            end
`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
            ST_SLEEP: if (any_req) state_d = ST_WAKE;
            ST_WAKE:  state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
        mem_rw_d = (state_d == ST_WRITE);
        a_ack_d  = ((state_d == ST_READ) || (state_d == ST_HOLD)) && (grant_d == PORT_A);
        b_ack_d  = ((state_d == ST_READ) || (state_d == ST_HOLD)) && (grant_d == PORT_B);
`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
        sleep_d  = (state_d == ST_SLEEP);
`endif
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PORT_A;
            grant_q    <= PORT_A;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            mem_rw_q   <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
            sleep_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            mem_rw_q   <= mem_rw_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
            sleep_q    <= sleep_d;
`endif
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_in   = mem_in_q;
    assign mem_rw   = mem_rw_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_mem_array_arbiter.sv
// Directed bench for mem_array_arbiter with a behavioural 8x8 array.
// The sleep checks follow MEM_ARRAY_ARBITER_SLEEP_EN.
module tb_mem_array_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_ack, b_ack, mem_rw, sleep;
    logic [7:0] a_rdata, b_rdata, mem_in, mem_out;
    logic [2:0] mem_addr;

    int checks = 0;
    int fails  = 0;
    logic sleep_c1;

    logic [7:0] mem [8];
    logic       pend;
    logic [7:0] karl [8] = '{8'h4B, 8'h61, 8'h72, 8'h6C, 8'h21, 8'h21, 8'h21, 8'h21};

    mem_array_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_rw(mem_rw),
        .mem_out(mem_out), .sleep(sleep)
    );

    always #5 clk = ~clk;

    // Array model: read is combinational; a write commits only once the
    // strobe has been followed by its hold cycle, so a strobe cut short by
    // reset leaves the old contents in place.
    assign mem_out = mem[mem_addr];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= mem_rw;
        if (pend && !rst) mem[mem_addr] <= mem_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Protocol watch: never both acks, never an ack without its req.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_both", {31'd0, a_ack & b_ack}, 0);
            chk("ack_noreq", {30'd0, a_ack & ~a_req, b_ack & ~b_req}, 0);
        end
    end

    task automatic reset_dut();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    // One transaction started from an idle/sleeping arbiter. Cycle 1 is the
    // cycle right after the edge that samples req, so a read acks in cycle 2,
    // a write strobes in cycle 2 and acks in cycle 3.
    task automatic xact(input bit pb, input bit we, input logic [2:0] ad,
                        input logic [7:0] wd, input int exp_lat,
                        input logic [7:0] exp_rd, input string tag);
        int cyc, rw_n, rw_c;
        bit got, stable;
        @(negedge clk);
        if (pb) begin b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; end
        else    begin a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; end
        @(posedge clk);
        cyc = 0; rw_n = 0; rw_c = 0; got = 1'b0; stable = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) sleep_c1 = sleep;
            if (mem_rw) begin rw_n++; rw_c = cyc; end
            if (we && cyc <= 3 && (mem_addr !== ad || mem_in !== wd)) stable = 1'b0;
            got = pb ? b_ack : a_ack;
        end
        #1;
        if (pb) b_req = 1'b0; else a_req = 1'b0;
        chk({tag, "_lat"}, cyc, exp_lat);
        if (we) begin
            chk({tag, "_rw_cnt"}, rw_n, 1);
            chk({tag, "_rw_cyc"}, rw_c, 2);
            chk({tag, "_stable"}, {31'd0, stable}, 1);
        end else begin
            chk({tag, "_rdata"}, pb ? b_rdata : a_rdata, exp_rd);
            chk({tag, "_rw_cnt"}, rw_n, 0);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, pb ? b_ack : a_ack}, 0);
    endtask

    initial begin
        int order [$];
        bit seen;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_a_ack", {31'd0, a_ack}, 0);
        chk("rst_b_ack", {31'd0, b_ack}, 0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 0);
        chk("rst_mem_addr", {29'd0, mem_addr}, 0);
        chk("rst_mem_in", {24'd0, mem_in}, 0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 0);
        chk("rst_sleep", {31'd0, sleep}, 0);
        rst = 1'b0;

        // Single write, then the full string through A and back through B
        xact(1'b0, 1'b1, 3'd0, 8'h4B, 3, 8'h00, "wr0");
        for (int i = 0; i < 8; i++) xact(1'b0, 1'b1, 3'(i), karl[i], 3, 8'h00, "karl_wr");
        for (int i = 0; i < 8; i++) xact(1'b1, 1'b0, 3'(i), 8'h00, 2, karl[i], "karl_rd");
        xact(1'b0, 1'b0, 3'd3, 8'h00, 2, 8'h6C, "a_rd3");
        chk("b_rdata_held", {24'd0, b_rdata}, 32'h21);

        // Simultaneous requests held through several acks: strict alternation
        reset_dut();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd2;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (a_ack) order.push_back(0);
            if (b_ack) order.push_back(1);
        end
        #1; a_req = 1'b0; b_req = 1'b0;
        chk("fair_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("fair_order", (i < order.size()) ? order[i] : 2, i % 2);
        chk("fair_a_rdata", {24'd0, a_rdata}, 32'h61);
        chk("fair_b_rdata", {24'd0, b_rdata}, 32'h72);

        // Reset landing in the middle of a write strobe
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 8'h99;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rstw_rw_on", {31'd0, mem_rw}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_rw_off", {31'd0, mem_rw}, 0);
        chk("rstw_no_ack", {31'd0, a_ack}, 0);
        a_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstw_no_ack_later", {31'd0, a_ack}, 0);
        end
        rst = 1'b0;
        xact(1'b0, 1'b0, 3'd0, 8'h00, 2, 8'h4B, "rstw_rd");

`ifdef MEM_ARRAY_ARBITER_SLEEP_EN
        // Ten idle cycles put the array to sleep; a read then pays 2 extra cycles
        reset_dut();
        repeat (9) @(negedge clk);
        chk("sleep_early", {31'd0, sleep}, 0);
        repeat (3) @(negedge clk);
        chk("sleep_on", {31'd0, sleep}, 1);
        xact(1'b0, 1'b0, 3'd3, 8'h00, 4, 8'h6C, "wake_rd");
        chk("sleep_off_c1", {31'd0, sleep_c1}, 0);
`else
        // Without the sleep feature the output never rises
        reset_dut();
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (sleep !== 1'b0) seen = 1'b1;
        end
        chk("no_sleep", {31'd0, seen}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
